// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC / branch-prediction slice:
// branch condition codes, 2-bit counter states and the BTB entry layout.
package pc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Fields sized for the widest supported PC; narrower tags/targets are zero-extended.
  localparam int BTB_FIELD_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/branch_resolve.sv
// Execute-stage control-flow resolution: evaluates the branch condition,
// computes the real target and flags a mismatch with the carried prediction.
module branch_resolve
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 64,
  parameter int REG_WIDTH = 64
) (
  input  logic                 valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_branch,
  input  logic                 ex_jal,
  input  logic                 ex_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [REG_WIDTH-1:0] ex_rs1,
  input  logic [REG_WIDTH-1:0] ex_rs2,
  input  logic [REG_WIDTH-1:0] ex_imm,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_pred_target,
  output logic                 taken,
  output logic [PC_WIDTH-1:0]  target,
  output logic [PC_WIDTH-1:0]  correct_next,
  output logic                 mispredict
);

  logic                cond;
  logic [PC_WIDTH-1:0] rs1_pc;
  logic [PC_WIDTH-1:0] imm_pc;
  logic [PC_WIDTH-1:0] jalr_sum;

  assign rs1_pc   = ex_rs1[PC_WIDTH-1:0];
  assign imm_pc   = ex_imm[PC_WIDTH-1:0];
  assign jalr_sum = rs1_pc + imm_pc;

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond = (ex_rs1 == ex_rs2);
      F3_BNE:  cond = (ex_rs1 != ex_rs2);
      F3_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond = (ex_rs1 <  ex_rs2);
      F3_BGEU: cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  // jal wins if decode ever raises more than one control flag.
  assign taken  = ex_jal | ex_jalr | (ex_branch & cond);
  assign target = (ex_jalr && !ex_jal) ? {jalr_sum[PC_WIDTH-1:1], 1'b0}
                                       : ex_pc + imm_pc;

  assign correct_next = taken ? target : ex_pc + PC_WIDTH'(4);
  assign mispredict   = valid &&
                        ((ex_pred_taken != taken) ||
                         (taken && (ex_pred_target != target)));

endmodule

// File: rtl/bpred_pc_unit.sv
// Registered fetch PC with a direct-mapped BTB plus 2-bit counters,
// redirected by execute-stage resolution with a one-cycle flush pulse.
module bpred_pc_unit
  import pc_pkg::*;
#(
  parameter int                PC_WIDTH    = 64,
  parameter int                REG_WIDTH   = 64,
  parameter int                BTB_ENTRIES = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_branch,
  input  logic                 ex_jal,
  input  logic                 ex_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [REG_WIDTH-1:0] ex_rs1,
  input  logic [REG_WIDTH-1:0] ex_rs2,
  input  logic [REG_WIDTH-1:0] ex_imm,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_pred_target,
  output logic                 flush,
  output logic [31:0]          mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

  btb_entry_t btb [BTB_ENTRIES];
  logic [1:0] ctr [BTB_ENTRIES];

  logic [IDX_W-1:0]    f_idx, x_idx;
  logic [TAG_W-1:0]    f_tag, x_tag;
  logic                f_hit, x_hit;
  logic                eff_valid;
  logic                taken;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] correct_next;
  logic                mispredict;

  assign f_idx = pc[2 +: IDX_W];
  assign f_tag = pc[PC_WIDTH-1 -: TAG_W];
  assign x_idx = ex_pc[2 +: IDX_W];
  assign x_tag = ex_pc[PC_WIDTH-1 -: TAG_W];

  assign f_hit = btb[f_idx].valid && (btb[f_idx].tag == BTB_FIELD_W'(f_tag));
  assign x_hit = btb[x_idx].valid && (btb[x_idx].tag == BTB_FIELD_W'(x_tag));

  assign pred_taken  = f_hit && ctr[f_idx][1];
  assign pred_target = pred_taken ? PC_WIDTH'(btb[f_idx].target)
                                  : pc + PC_WIDTH'(4);

  // The instruction in execute during a flush cycle is wrong-path.
  assign eff_valid = ex_valid && !flush;

  branch_resolve #(
    .PC_WIDTH  (PC_WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_resolve (
    .valid          (eff_valid),
    .ex_pc          (ex_pc),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .taken          (taken),
    .target         (target),
    .correct_next   (correct_next),
    .mispredict     (mispredict)
  );

  // Table training; the combinational predict path above reads the pre-edge entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i] <= '0;
        ctr[i] <= WNT;
      end
    end else if (eff_valid) begin
      if (ex_jal || ex_jalr) begin
        btb[x_idx] <= '{valid: 1'b1, tag: BTB_FIELD_W'(x_tag), target: BTB_FIELD_W'(target)};
        ctr[x_idx] <= ST;
      end else if (ex_branch) begin
        if (x_hit) begin
          if (taken) begin
            if (ctr[x_idx] != ST) ctr[x_idx] <= ctr[x_idx] + 2'd1;
            if (btb[x_idx].target != BTB_FIELD_W'(target))
              btb[x_idx].target <= BTB_FIELD_W'(target);
          end else if (ctr[x_idx] != SNT) begin
            ctr[x_idx] <= ctr[x_idx] - 2'd1;
          end
        end else if (taken) begin
          btb[x_idx] <= '{valid: 1'b1, tag: BTB_FIELD_W'(x_tag), target: BTB_FIELD_W'(target)};
          ctr[x_idx] <= WT;
        end
      end else if (mispredict) begin
        btb[x_idx].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= RESET_PC;
      flush            <= 1'b0;
      mispredict_count <= '0;
    end else if (mispredict) begin
      pc    <= correct_next;
      flush <= 1'b1;
      if (mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end else begin
      flush <= 1'b0;
      if (!stall) pc <= pred_target;
    end
  end

endmodule

// File: tb/tb_bpred_pc_unit.sv
// Directed plus randomized bench for bpred_pc_unit, checked against a
// table-of-records reference model of the predictor and resolver.
module tb_bpred_pc_unit;

  localparam int N          = 16;
  localparam int LINE_SHIFT = 2 + $clog2(N);

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [63:0] pc, pred_target;
  logic        pred_taken;
  logic        ex_valid, ex_branch, ex_jal, ex_jalr, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_target;
  logic        flush;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: per slot, the full PC that owns it.
  logic [63:0] m_pc;
  bit          m_flush;
  logic [31:0] m_cnt;
  bit          m_valid [N];
  logic [63:0] m_owner [N];
  logic [63:0] m_tgt   [N];
  int          m_ctr   [N];

  bpred_pc_unit #(
    .PC_WIDTH    (64),
    .REG_WIDTH   (64),
    .BTB_ENTRIES (N),
    .RESET_PC    (64'h1000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .pc               (pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_branch        (ex_branch),
    .ex_jal           (ex_jal),
    .ex_jalr          (ex_jalr),
    .ex_funct3        (ex_funct3),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .flush            (flush),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int slot(input logic [63:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit same_line(input logic [63:0] a, input logic [63:0] b);
    return (a >> LINE_SHIFT) == (b >> LINE_SHIFT);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // kind: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr
  task automatic applyStimulus(input bit r, input bit st, input bit v, input int kind,
                               input logic [2:0] f3, input logic [63:0] xpc,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] imm, input bit ptk,
                               input logic [63:0] ptgt);
    rst = r; stall = st; ex_valid = v;
    ex_branch = (kind == 1); ex_jal = (kind == 2); ex_jalr = (kind == 3);
    ex_funct3 = f3; ex_pc = xpc; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic idle(input bit st);
    applyStimulus(0, st, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 64'h0);
  endtask

  // One clock: check predictions, advance the model, clock the DUT, check state.
  task automatic step(input bit chk_pred);
    bit          hit, epk, tk, eff, mis;
    logic [63:0] eptgt, tg, npc;
    int          i, j;
    #1;
    i     = slot(m_pc);
    hit   = m_valid[i] && same_line(m_owner[i], m_pc);
    epk   = hit && (m_ctr[i] >= 2);
    eptgt = epk ? m_tgt[i] : m_pc + 64'd4;
    if (chk_pred) begin
      checkOutput("pred_taken", {63'b0, pred_taken}, {63'b0, epk});
      checkOutput("pred_target", pred_target, eptgt);
    end

    tk = 0;
    tg = ex_pc + ex_imm;
    if (ex_jal) tk = 1;
    else if (ex_jalr) begin
      tk = 1;
      tg = (ex_rs1 + ex_imm) & ~64'd1;
    end else if (ex_branch) begin
      case (ex_funct3)
        3'd0: tk = (ex_rs1 == ex_rs2);
        3'd1: tk = (ex_rs1 != ex_rs2);
        3'd4: tk = (longint'(ex_rs1) <  longint'(ex_rs2));
        3'd5: tk = (longint'(ex_rs1) >= longint'(ex_rs2));
        3'd6: tk = (ex_rs1 <  ex_rs2);
        3'd7: tk = (ex_rs1 >= ex_rs2);
        default: tk = 0;
      endcase
    end
    eff = !rst && ex_valid && !m_flush;
    mis = eff && ((ex_pred_taken != tk) || (tk && ex_pred_target != tg));

    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 64'h1000; m_flush = 0; m_cnt = 0;
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0; m_owner[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
    end else begin
      npc = m_pc;
      if (mis) begin
        npc = tk ? tg : ex_pc + 64'd4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (!stall) npc = eptgt;
      m_pc    = npc;
      m_flush = mis;
      if (eff) begin
        j = slot(ex_pc);
        if (ex_jal || ex_jalr) begin
          m_valid[j] = 1; m_owner[j] = ex_pc; m_tgt[j] = tg; m_ctr[j] = 3;
        end else if (ex_branch) begin
          if (m_valid[j] && same_line(m_owner[j], ex_pc)) begin
            m_ctr[j] = tk ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                          : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
            if (tk) m_tgt[j] = tg;
          end else if (tk) begin
            m_valid[j] = 1; m_owner[j] = ex_pc; m_tgt[j] = tg; m_ctr[j] = 2;
          end
        end else if (mis) begin
          m_valid[j] = 0;
        end
      end
    end
    checkOutput("pc", pc, m_pc);
    checkOutput("flush", {63'b0, flush}, {63'b0, m_flush});
    checkOutput("mispredict_count", {32'b0, mispredict_count}, {32'b0, m_cnt});
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'd0;
      2: return 64'd1;
      3: return 64'd5;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [31:0] cnt_before;
    logic [63:0] xpc, imm;
    int          kind;

    applyStimulus(1, 0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 64'h0);
    step(0);
    checkOutput("rst_pc", pc, 64'h1000);
    checkOutput("rst_pred_taken", {63'b0, pred_taken}, 64'd0);

    for (int k = 0; k < 3; k++) begin
      idle(0);
      step(1);
    end
    checkOutput("seq_pc", pc, 64'h100C);

    // beq taken, predicted not-taken: redirect and allocate
    applyStimulus(0, 0, 1, 1, 3'd0, 64'h1000, 64'd5, 64'd5, 64'h40, 0, 64'h0);
    step(1);
    checkOutput("beq_pc", pc, 64'h1040);
    checkOutput("beq_flush", {63'b0, flush}, 64'd1);
    idle(0);
    step(1);

    // A non-control instruction predicted taken steers fetch back to 0x1000
    applyStimulus(0, 0, 1, 0, 3'd0, 64'hFFC, 64'h0, 64'h0, 64'h0, 1, 64'h0);
    step(1);
    checkOutput("alias_pc", pc, 64'h1000);
    checkOutput("hit_pred_taken", {63'b0, pred_taken}, 64'd1);
    checkOutput("hit_pred_target", pred_target, 64'h1040);
    idle(0);
    step(1);

    applyStimulus(0, 0, 1, 1, 3'd0, 64'h1000, 64'd5, 64'd6, 64'h40, 1, 64'h1040);
    step(1);
    checkOutput("beq_nt_pc", pc, 64'h1004);

    // Flush cycle: a would-be mispredict must be ignored
    cnt_before = mispredict_count;
    applyStimulus(0, 0, 1, 1, 3'd0, 64'h1000, 64'd5, 64'd5, 64'h40, 0, 64'h0);
    step(1);
    checkOutput("flush_ignore_cnt", {32'b0, mispredict_count}, {32'b0, cnt_before});
    checkOutput("flush_ignore_flush", {63'b0, flush}, 64'd0);

    applyStimulus(0, 0, 1, 1, 3'd0, 64'h1000, 64'd5, 64'd6, 64'h40, 0, 64'h0);
    step(1);
    applyStimulus(0, 0, 1, 0, 3'd0, 64'hFFC, 64'h0, 64'h0, 64'h0, 1, 64'h0);
    step(1);
    checkOutput("weak_pred_taken", {63'b0, pred_taken}, 64'd0);
    checkOutput("weak_pred_target", pred_target, 64'h1004);
    idle(0);
    step(1);

    // jalr clears bit 0 of the computed target
    applyStimulus(0, 0, 1, 3, 3'd0, 64'h1100, 64'h2001, 64'h0, 64'd4, 1, 64'h2004);
    step(1);
    checkOutput("jalr_ok_flush", {63'b0, flush}, 64'd0);
    applyStimulus(0, 0, 1, 3, 3'd0, 64'h1100, 64'h2001, 64'h0, 64'd4, 1, 64'h3000);
    step(1);
    checkOutput("jalr_bad_pc", pc, 64'h2004);
    checkOutput("jalr_bad_flush", {63'b0, flush}, 64'd1);
    idle(0);
    step(1);

    // Mispredict overrides stall, then stall holds the PC
    applyStimulus(0, 1, 1, 2, 3'd0, 64'h1200, 64'h0, 64'h0, 64'h100, 0, 64'h0);
    step(1);
    checkOutput("stall_redirect_pc", pc, 64'h1300);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      step(1);
      checkOutput("stall_hold_pc", pc, 64'h1300);
    end

    applyStimulus(0, 0, 1, 1, 3'd4, 64'h1400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 0, 64'h0);
    step(1);
    checkOutput("blt_pc", pc, 64'h1420);
    idle(0);
    step(1);
    applyStimulus(0, 0, 1, 1, 3'd6, 64'h1400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 0, 64'h0);
    step(1);
    checkOutput("bltu_flush", {63'b0, flush}, 64'd0);

    // Randomized traffic over a few cache lines so slots alias and retrain
    for (int k = 0; k < 400; k++) begin
      xpc  = 64'h1000 + 64'(4 * $urandom_range(0, 40));
      imm  = 64'(longint'($urandom_range(0, 64)) * 4 - 128);
      kind = int'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0), kind, 3'($urandom_range(0, 7)), xpc,
                    pick_val(), pick_val(), imm, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? xpc + imm : xpc + 64'(4 * $urandom_range(0, 8)));
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bpred_pc_unit.md
Name: bpred_pc_unit

Overview:
- Registered fetch-PC generator for the pipelined core.
- Predicts the next fetch PC with a direct-mapped BTB and 2-bit saturating counters.
- Resolves conditional branches (beq/bne/blt/bge/bltu/bgeu), jal and jalr from the execute stage, then redirects the PC and raises a one-cycle flush on a mispredict.
- Sits between the instruction-fetch stage and the execute-stage ALU.

Parameters:
- PC_WIDTH, 64, width of program counter and targets.
- REG_WIDTH, 64, width of rs1/rs2/imm operands.
- BTB_ENTRIES, 16, number of BTB/counter entries; power of 2, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch PC (front-end backpressure).
- pc  out  PC_WIDTH  current fetch PC (registered).
- pred_taken  out  1  prediction for pc (combinational).
- pred_target  out  PC_WIDTH  predicted next PC for pc (combinational).
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  PC_WIDTH  PC of the execute-stage instruction.
- ex_branch  in  1  conditional branch.
- ex_jal  in  1  jal.
- ex_jalr  in  1  jalr.
- ex_funct3  in  3  branch condition.
- ex_rs1  in  REG_WIDTH  source operand 1.
- ex_rs2  in  REG_WIDTH  source operand 2.
- ex_imm  in  REG_WIDTH  sign-extended immediate.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  PC_WIDTH  predicted target carried down the pipe.
- flush  out  1  registered one-cycle mispredict pulse.
- mispredict_count  out  32  saturating mispredict counter.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and overrides everything.
- Reset values:
  - pc = RESET_PC, flush = 0, mispredict_count = 0.
  - All BTB valid bits = 0; all counters = 2'b01.
- Indexing: IDX_W = $clog2(BTB_ENTRIES); idx = pc[2 +: IDX_W]; tag = pc[PC_WIDTH-1 : 2+IDX_W].
- Predict (combinational):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : pc+4.
- Resolve (combinational):
  - eff_valid = ex_valid && !flush. Execute inputs are ignored in the flush cycle because that instruction is wrong-path.
  - Branch taken conditions:
    - beq: rs1 == rs2.
    - bne: rs1 != rs2.
    - blt / bge: signed compare.
    - bltu / bgeu: unsigned compare.
    - funct3 2 or 3: not taken.
  - jal and jalr are always taken.
  - Targets: branch/jal = ex_pc + ex_imm; jalr = (ex_rs1 + ex_imm) with bit 0 cleared.
  - Arithmetic is mod 2^PC_WIDTH; operands are truncated to PC_WIDTH.
  - correct_next = taken ? target : ex_pc+4.
  - mispredict = eff_valid && (ex_pred_taken != taken || (taken && ex_pred_target != target)).
  - A non-control instruction predicted taken (alias) counts as a mispredict to ex_pc+4.
- PC register priority, high to low:
  1. rst.
  2. mispredict: pc <= correct_next; flush <= 1.
  3. stall: hold pc.
  4. otherwise pc <= pred_target.
  - flush = 0 whenever no mispredict is registered.
  - mispredict has priority over stall.
- Table update on the clock edge when eff_valid (index and tag taken from ex_pc):
  - Branch, tag hit: counter increments if taken, decrements if not; saturates at 3 and 0.
  - Branch, taken, miss: allocate entry; counter = 2'b10.
  - Branch, not taken, miss: no allocation.
  - jal/jalr: allocate or refresh entry; counter = 2'b11.
  - Any allocation writes the target, writes the tag and sets valid. A taken hit with a changed target rewrites the target.
  - Alias mispredict: clear valid[idx].
- Read-before-write: a prediction and an update to the same index in the same cycle see the old entry.
- mispredict_count increments per mispredict and holds at 32'hFFFF_FFFF.
- Reset mid-operation: rst discards any pending redirect; the next cycle outputs pc = RESET_PC and flush = 0.

Decomposition:
- Shared package pc_pkg:
  - funct3 localparams F3_BEQ..F3_BGEU.
  - 2-bit counter constants (SNT, WNT, WT, ST).
  - btb_entry_t struct {valid, tag, target}.
- One natural sub-module: branch_resolve. It is combinational and computes taken, target, correct_next and mispredict from the ex_* inputs.

Test Plan:
- Reset with RESET_PC=0x1000 -> pc=0x1000, flush=0, pred_taken=0. Then 3 cycles with no stall -> pc=0x1004, 0x1008, 0x100C.
- beq at 0x1000, rs1=rs2=5, imm=0x40, ex_pred_taken=0 -> flush=1 for one cycle and pc=0x1040. The next fetch of 0x1000 gives pred_taken=1 and pred_target=0x1040.
- Same beq resolved not-taken twice -> counter goes 10 -> 01 -> 00; the first not-taken resolve flushes to 0x1004, and the next fetch of 0x1000 gives pred_target=0x1004.
- jalr with rs1=0x2001, imm=4, predicted 0x2004 -> target 0x2004 (bit 0 cleared), no flush. With a predicted target of 0x3000 instead -> flush and pc=0x2004.
- stall=1 asserted together with a mispredict -> redirect taken anyway. Afterwards, stall holds pc constant for 4 cycles.
- blt with rs1=-1, rs2=1 -> taken; bltu with the same values -> not taken. ex_valid asserted in the flush cycle -> ignored: no counter change and mispredict_count unchanged.
